// File: rtl/pwm_from_count.sv
// PWM generator slaved to an upstream down counter: locks onto the 0 -> max wrap,
// then compares the count against a duty threshold that only changes at a wrap.
module pwm_from_count #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] count,
    input  logic [N-1:0] duty_data,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         update_ack,
    output logic         pwm_out,
    output logic         period_tick,
    output logic [7:0]   period_cnt,
    output logic [1:0]   fsm_state
);

    // Encoding is visible on fsm_state: IDLE=0, SYNC=1, RUN=2.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [N-1:0] COUNT_MAX = '1;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] prev_count;
    logic         prev_valid;
    logic         pending;
    logic [N-1:0] pend_duty;
    logic [N-1:0] active_duty;
    logic [N-1:0] eff_duty;
    logic         wrap;
    logic         synced;
    logic         apply;

    // Duty handshake: a value transfers on a cycle where duty_valid and
    // duty_ready are both high; duty_ready is low while a value is pending.
    assign duty_ready = !pending;
    assign fsm_state  = state;

    assign wrap     = en && prev_valid && (prev_count == '0) && (count == COUNT_MAX);
    assign synced   = (state == SYNC) || (state == RUN);
    assign apply    = wrap && pending && synced;
    // The compare in the wrap cycle already uses the duty that takes effect there.
    assign eff_duty = (wrap && pending) ? pend_duty : active_duty;

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SYNC;
                SYNC:    state_next = wrap ? RUN : SYNC;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev_count  <= '0;
            prev_valid  <= 1'b0;
            pending     <= 1'b0;
            pend_duty   <= '0;
            active_duty <= '0;
            pwm_out     <= 1'b0;
            update_ack  <= 1'b0;
            period_tick <= 1'b0;
            period_cnt  <= 8'd0;
        end else begin
            state      <= state_next;
            prev_count <= count;
            prev_valid <= en;

            // Acceptance and application are exclusive: accept needs pending=0.
            if (duty_valid && !pending) begin
                pend_duty <= duty_data;
                pending   <= 1'b1;
            end else if (apply) begin
                active_duty <= pend_duty;
                pending     <= 1'b0;
            end

            update_ack  <= apply;
            period_tick <= wrap && synced;
            if (wrap && (state == RUN)) begin
                period_cnt <= period_cnt + 8'd1;
            end
            pwm_out <= (state_next == RUN) && (count < eff_duty);
        end
    end

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed bench for pwm_from_count (N=4): driver pushes the expected output
// vector of every cycle into a queue, a monitor pops and compares after each edge.
module tb_pwm_from_count;

    localparam int W = 14;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] count;
    logic [3:0] duty_data;
    logic       duty_valid;
    logic       duty_ready;
    logic       update_ack;
    logic       pwm_out;
    logic       period_tick;
    logic [7:0] period_cnt;
    logic [1:0] fsm_state;

    // {state[13:12], pwm[11], ack[10], tick[9], pcnt[8:1], ready[0]}
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    bit done = 1'b0;

    pwm_from_count #(.N(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .count      (count),
        .duty_data  (duty_data),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .update_ack (update_ack),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .period_cnt (period_cnt),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle_no, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycle(input bit rst_v, input int pcnt, input bit ready);
        @(negedge clk);
        reset      = rst_v;
        en         = 1'b0;
        count      = 4'd0;
        duty_valid = 1'b0;
        duty_data  = 4'd0;
        exp_q.push_back({S_IDLE, 1'b0, 1'b0, 1'b0, 8'(pcnt), ready});
    endtask

    // Drives counts 15,14,...; index 0 is the 15 that may form a wrap.
    task automatic period(input int len, input int en_off, input logic [1:0] st,
                          input bit ack, input bit tick, input int pcnt, input int duty,
                          input bit ready0,
                          input int o1_idx, input int o1_val, input bit o1_acc,
                          input int o2_idx, input int o2_val, input bit o2_acc);
        bit         r;
        bit         pwm_e;
        logic [1:0] st_e;
        int         c;
        r = ready0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            c          = 15 - k;
            count      = 4'(c);
            en         = (k < en_off);
            duty_valid = (k == o1_idx) || (k == o2_idx);
            duty_data  = (k == o2_idx) ? 4'(o2_val) : 4'(o1_val);
            st_e       = (k < en_off) ? st : S_IDLE;
            pwm_e      = (st_e == S_RUN) && (c < duty);
            if (k == o1_idx && o1_acc) r = 1'b0;
            if (k == o2_idx && o2_acc) r = 1'b0;
            exp_q.push_back({st_e, pwm_e, (k == 0) ? ack : 1'b0, (k == 0) ? tick : 1'b0,
                             8'(pcnt), r});
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",       32'(fsm_state),   32'(e[13:12]));
                check("pwm_out",     32'(pwm_out),     32'(e[11]));
                check("update_ack",  32'(update_ack),  32'(e[10]));
                check("period_tick", 32'(period_tick), 32'(e[9]));
                check("period_cnt",  32'(period_cnt),  32'(e[8:1]));
                check("duty_ready",  32'(duty_ready),  32'(e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; en = 1'b0; count = 4'd0; duty_valid = 1'b0; duty_data = 4'd0;
        idle_cycle(1'b1, 0, 1'b1);
        idle_cycle(1'b1, 0, 1'b1);
        idle_cycle(1'b0, 0, 1'b1);

        // lead-in in SYNC, offer 5
        period(16, 16, S_SYNC, 0, 0, 0, 0, 1'b1, 4, 5, 1'b1, -1, 0, 1'b0);
        // first wrap: SYNC->RUN, 5 applied, count not incremented
        period(16, 16, S_RUN, 1, 1, 0, 5, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        // offer 9 in the wrap cycle: not applied at this wrap
        period(16, 16, S_RUN, 0, 1, 1, 5, 1'b1, 0, 9, 1'b1, -1, 0, 1'b0);
        // 9 applied; offer 13 accepted, then 3 ignored while pending
        period(16, 16, S_RUN, 1, 1, 2, 9, 1'b1, 3, 13, 1'b1, 8, 3, 1'b0);
        // 13 applied; offer 0
        period(16, 16, S_RUN, 1, 1, 3, 13, 1'b1, 5, 0, 1'b1, -1, 0, 1'b0);
        // duty 0: constant low; offer 15
        period(16, 16, S_RUN, 1, 1, 4, 0, 1'b1, 2, 15, 1'b1, -1, 0, 1'b0);
        // duty 15: one low cycle per period
        period(16, 16, S_RUN, 1, 1, 5, 15, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        // offer 7, then drop en mid-period; 7 stays pending
        period(16, 10, S_RUN, 0, 1, 6, 15, 1'b1, 2, 7, 1'b1, -1, 0, 1'b0);
        // en back: no wrap on first 15 (no valid previous sample)
        period(16, 16, S_SYNC, 0, 0, 6, 0, 1'b0, -1, 0, 1'b0, -1, 0, 1'b0);
        // resync wrap applies retained 7
        period(16, 16, S_RUN, 1, 1, 6, 7, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        // long run through the 255 -> 0 rollover of period_cnt
        for (int p = 7; p <= 260; p++) begin
            period(16, 16, S_RUN, 0, 1, p % 256, 7, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        end
        // partial period with 11 pending, reset lands while pwm_out is high
        period(12, 16, S_RUN, 0, 1, 5, 7, 1'b1, 3, 11, 1'b1, -1, 0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pwm",   32'(pwm_out),     32'd0);
        check("async_rst_ack",   32'(update_ack),  32'd0);
        check("async_rst_tick",  32'(period_tick), 32'd0);
        check("async_rst_pcnt",  32'(period_cnt),  32'd0);
        check("async_rst_ready", 32'(duty_ready),  32'd1);
        check("async_rst_state", 32'(fsm_state),   32'(S_IDLE));
        idle_cycle(1'b1, 0, 1'b1);
        idle_cycle(1'b1, 0, 1'b1);
        idle_cycle(1'b0, 0, 1'b1);
        // resync; pending 11 and active 7 were discarded, so output stays low
        period(16, 16, S_SYNC, 0, 0, 0, 0, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        period(16, 16, S_RUN, 0, 1, 0, 0, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        period(16, 16, S_RUN, 0, 1, 1, 0, 1'b1, -1, 0, 1'b0, -1, 0, 1'b0);
        duty_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        if (!done) begin
            done = 1'b1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #300000;
        if (!done) begin
            done = 1'b1;
            checks++;
            errors++;
            $display("FAIL watchdog cycle=%0d actual=timeout required=completion", cycle_no);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
